// File: rtl/single_port_ram_pkg.sv
// Control encodings shared with the single-port SRAM buffer.
package single_port_ram_pkg;
  localparam logic CS_ENB   = 1'b1;
  localparam logic CS_DIS   = 1'b0;
  localparam logic OE_ENB   = 1'b1;
  localparam logic OE_DIS   = 1'b0;
  localparam logic WREQ_DIS = 1'b0;
endpackage

// File: rtl/strided_fifo_producer_if.sv
// Buffer-arbitration, SRAM and FIFO-push signals of the strided producer.
interface strided_fifo_producer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 20,
  parameter int SPACE_WIDTH = 5
);
  logic                   request;
  logic                   grant;
  logic                   fifo_full;
  logic [SPACE_WIDTH-1:0] fifo_space;
  logic                   fifo_w_en;
  logic [DATA_WIDTH-1:0]  fifo_data_in;
  logic                   buf_cs;
  logic                   buf_oe;
  logic [ADDR_WIDTH-1:0]  buf_addr;
  logic [DATA_WIDTH-1:0]  buf_r_data;
  logic                   buf_w_req;
  logic [DATA_WIDTH-1:0]  buf_w_data;

  modport master (
    output request, fifo_w_en, fifo_data_in, buf_cs, buf_oe, buf_addr, buf_w_req, buf_w_data,
    input  grant, fifo_full, fifo_space, buf_r_data
  );

  modport slave (
    input  request, fifo_w_en, fifo_data_in, buf_cs, buf_oe, buf_addr, buf_w_req, buf_w_data,
    output grant, fifo_full, fifo_space, buf_r_data
  );
endinterface

// File: rtl/strided_fifo_producer.sv
// 2-D strided tile streamer: reads SRAM in credit-checked, arbitrated bursts
// and pushes the words in order into a sync FIFO.
module strided_fifo_producer
  import single_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 20,
  parameter int BURST_SIZE  = 4,
  parameter int CNT_WIDTH   = 10,
  parameter int SPACE_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] cfg_addr_begin,
  input  logic [ADDR_WIDTH-1:0] cfg_inner_step,
  input  logic [CNT_WIDTH-1:0]  cfg_inner_cnt,
  input  logic [ADDR_WIDTH-1:0] cfg_outer_step,
  input  logic [CNT_WIDTH-1:0]  cfg_outer_cnt,
  output logic                  overflow_err,
  strided_fifo_producer_if.master bus
);

  localparam int REM_W = 2 * CNT_WIDTH;
  localparam int BL_W  = $clog2(BURST_SIZE + 1);
  localparam int CMP_W = ((SPACE_WIDTH > BL_W) ? SPACE_WIDTH : BL_W) + 1;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_WAIT  = 5'b00010,
    S_BURST = 5'b00100,
    S_DRAIN = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] inner_step;
  logic [ADDR_WIDTH-1:0] outer_step;
  logic [CNT_WIDTH-1:0]  inner_cnt;
  logic [CNT_WIDTH-1:0]  col;
  logic [REM_W-1:0]      remaining;
  logic [BL_W-1:0]       burst_left;
  logic                  inflight;

  logic [REM_W-1:0]      total_cnt;
  logic [BL_W-1:0]       blen;
  logic                  space_ok;
  logic                  issue;
  logic                  last_col;
  logic                  burst_go;

  assign total_cnt = REM_W'(cfg_inner_cnt) * REM_W'(cfg_outer_cnt);
  assign blen      = (remaining >= REM_W'(BURST_SIZE)) ? BL_W'(BURST_SIZE) : remaining[BL_W-1:0];
  // The word still in flight will also land in the FIFO, so it consumes a credit.
  assign space_ok  = CMP_W'(bus.fifo_space) >= (CMP_W'(blen) + CMP_W'(inflight));
  assign burst_go  = (state == S_WAIT) && bus.grant && space_ok;
  assign issue     = (state == S_BURST) && bus.grant;
  assign last_col  = (col == (inner_cnt - CNT_WIDTH'(1)));

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output and next-state value gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next       = state;
    busy             = (state != S_IDLE);
    done             = (state == S_DONE);
    bus.request      = (state == S_WAIT) || (state == S_BURST);
    bus.buf_cs       = issue ? CS_ENB : CS_DIS;
    bus.buf_oe       = issue ? OE_ENB : OE_DIS;
    bus.buf_addr     = addr;
    bus.buf_w_req    = WREQ_DIS;
    bus.buf_w_data   = '0;
    bus.fifo_w_en    = inflight && !bus.fifo_full;
    bus.fifo_data_in = '0;
    if (bus.fifo_w_en) bus.fifo_data_in = bus.buf_r_data;

    case (state)
      S_IDLE:  if (start) state_next = (total_cnt == '0) ? S_DONE : S_WAIT;
      S_WAIT:  if (burst_go) state_next = S_BURST;
      S_BURST: begin
        if (issue && (burst_left == BL_W'(1)))
          state_next = (remaining == REM_W'(1)) ? S_DRAIN : S_WAIT;
      end
      S_DRAIN: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr         <= '0;
      row_base     <= '0;
      inner_step   <= '0;
      outer_step   <= '0;
      inner_cnt    <= '0;
      col          <= '0;
      remaining    <= '0;
      burst_left   <= '0;
      inflight     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      inflight <= issue;
      if (inflight && bus.fifo_full) overflow_err <= 1'b1;

      if ((state == S_IDLE) && start) begin
        addr       <= cfg_addr_begin;
        row_base   <= cfg_addr_begin;
        inner_step <= cfg_inner_step;
        outer_step <= cfg_outer_step;
        inner_cnt  <= cfg_inner_cnt;
        col        <= '0;
        remaining  <= total_cnt;
      end

      if (burst_go) burst_left <= blen;

      // Address walks the row incrementally; a row wrap jumps to the next row base.
      if (issue) begin
        remaining  <= remaining - REM_W'(1);
        burst_left <= burst_left - BL_W'(1);
        if (last_col) begin
          col      <= '0;
          row_base <= row_base + outer_step;
          addr     <= row_base + outer_step;
        end else begin
          col      <= col + CNT_WIDTH'(1);
          addr     <= addr + inner_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_strided_fifo_producer.sv
// Directed bench for strided_fifo_producer: expected reads and pushes go into
// queues, and a negedge monitor pops and compares whenever the DUT acts.
module tb_strided_fifo_producer;
  import single_port_ram_pkg::*;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int BS = 4;
  localparam int CW = 10;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] cfg_addr_begin;
  logic [AW-1:0] cfg_inner_step;
  logic [CW-1:0] cfg_inner_cnt;
  logic [AW-1:0] cfg_outer_step;
  logic [CW-1:0] cfg_outer_cnt;
  logic          overflow_err;

  strided_fifo_producer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SPACE_WIDTH(SW)) bus ();

  strided_fifo_producer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_SIZE(BS), .CNT_WIDTH(CW), .SPACE_WIDTH(SW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .cfg_addr_begin (cfg_addr_begin),
    .cfg_inner_step (cfg_inner_step),
    .cfg_inner_cnt  (cfg_inner_cnt),
    .cfg_outer_step (cfg_outer_step),
    .cfg_outer_cnt  (cfg_outer_cnt),
    .overflow_err   (overflow_err),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'(a ^ (a >> 7) ^ 20'h3C5A1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SRAM model: data appears one cycle after the read is issued.
  always @(posedge clk)
    if (bus.buf_cs == CS_ENB && bus.buf_oe == OE_ENB)
      bus.buf_r_data <= mem_word(bus.buf_addr);

  // Monitor: every read and every push is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (bus.buf_cs == CS_ENB) begin
      check("read_expected", 32'(addr_q.size() != 0), 1);
      check("read_oe", 32'(bus.buf_oe), 32'(OE_ENB));
      if (addr_q.size() != 0) check("read_addr", bus.buf_addr, addr_q.pop_front());
    end
    if (bus.fifo_w_en === 1'b1) begin
      check("push_expected", 32'(data_q.size() != 0), 1);
      check("push_not_full", 32'(bus.fifo_full), 0);
      if (data_q.size() != 0) check("push_data", bus.fifo_data_in, data_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input logic [AW-1:0] a, input bit pushed);
    addr_q.push_back(a);
    if (pushed) data_q.push_back(mem_word(a));
  endtask

  task automatic start_xfer(input logic [AW-1:0] a0, input logic [AW-1:0] is,
                            input logic [CW-1:0] ic, input logic [AW-1:0] os,
                            input logic [CW-1:0] oc);
    cfg_addr_begin = a0;
    cfg_inner_step = is;
    cfg_inner_cnt  = ic;
    cfg_outer_step = os;
    cfg_outer_cnt  = oc;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_addr_begin = 20'hABCDE;
    cfg_inner_step = 20'h00777;
    cfg_inner_cnt  = 10'd99;
    cfg_outer_step = 20'h12345;
    cfg_outer_cnt  = 10'd77;
  endtask

  // Counts negedges until done; then confirms the pulse lasts one cycle.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("done_seen", 32'(lat >= 0), 1);
    tick();
    @(negedge clk);
    check("done_single_pulse", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
    tick();
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_reads_left"}, 32'(addr_q.size()), 0);
    check({tag, "_pushes_left"}, 32'(data_q.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_request"}, 32'(bus.request), 0);
    check({tag, "_fifo_w_en"}, 32'(bus.fifo_w_en), 0);
    check({tag, "_fifo_data_in"}, 32'(bus.fifo_data_in), 0);
    check({tag, "_buf_addr"}, 32'(bus.buf_addr), 0);
    check({tag, "_overflow_err"}, 32'(overflow_err), 0);
    check({tag, "_buf_cs"}, 32'(bus.buf_cs), 32'(CS_DIS));
    check({tag, "_buf_oe"}, 32'(bus.buf_oe), 32'(OE_DIS));
    check({tag, "_buf_w_req"}, 32'(bus.buf_w_req), 32'(WREQ_DIS));
  endtask

  initial begin
    int lat;
    rstn = 1'b0;
    start = 1'b0;
    cfg_addr_begin = '0;
    cfg_inner_step = '0;
    cfg_inner_cnt  = '0;
    cfg_outer_step = '0;
    cfg_outer_cnt  = '0;
    bus.grant      = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.fifo_space = 5'd16;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    rstn = 1'b1;
    tick();

    // 1: one row of 8, two bursts of 4
    bus.grant = 1'b1;
    for (int i = 0; i < 8; i++) expect_rd(20'h100 + AW'(i), 1'b1);
    start_xfer(20'h100, 20'h1, 10'd8, 20'h0, 10'd1);
    wait_done(lat);
    check("t1_done_latency", 32'(lat), 11);
    check_queues("t1");

    // 2: two rows of 3 with outer step, final burst of 2
    expect_rd(20'h10, 1'b1); expect_rd(20'h12, 1'b1); expect_rd(20'h14, 1'b1);
    expect_rd(20'h50, 1'b1); expect_rd(20'h52, 1'b1); expect_rd(20'h54, 1'b1);
    start_xfer(20'h10, 20'h2, 10'd3, 20'h40, 10'd2);
    wait_done(lat);
    check("t2_done_latency", 32'(lat), 9);
    check_queues("t2");

    // 3: negative step wrapping below zero
    expect_rd(20'h00001, 1'b1); expect_rd(20'h00000, 1'b1); expect_rd(20'hFFFFF, 1'b1);
    start_xfer(20'h1, 20'hFFFFF, 10'd3, 20'h0, 10'd1);
    wait_done(lat);
    check("t3_done_latency", 32'(lat), 5);
    check("t3_no_error", 32'(overflow_err), 0);
    check_queues("t3");

    // 4a: credit check holds WAIT until space covers the burst
    bus.fifo_space = 5'd3;
    for (int i = 0; i < 8; i++) expect_rd(20'h200 + AW'(i), 1'b1);
    start_xfer(20'h200, 20'h1, 10'd8, 20'h0, 10'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_wait_no_cs", 32'(bus.buf_cs), 32'(CS_DIS));
      check("t4_wait_request", 32'(bus.request), 1);
    end
    tick();
    bus.fifo_space = 5'd4;
    tick();
    @(negedge clk);
    check("t4_burst_starts", 32'(bus.buf_cs), 32'(CS_ENB));
    wait_done(lat);
    check_queues("t4a");

    // 4b: grant dropped for 2 cycles mid-burst
    bus.fifo_space = 5'd16;
    for (int i = 0; i < 4; i++) expect_rd(20'h300 + AW'(i), 1'b1);
    start_xfer(20'h300, 20'h1, 10'd4, 20'h0, 10'd1);
    tick();
    tick();
    tick();
    bus.grant = 1'b0;
    @(negedge clk);
    check("t4_pause1_addr", bus.buf_addr, 20'h302);
    check("t4_pause1_push", 32'(bus.fifo_w_en), 1);
    check("t4_pause1_request", 32'(bus.request), 1);
    tick();
    @(negedge clk);
    check("t4_pause2_addr", bus.buf_addr, 20'h302);
    check("t4_pause2_no_push", 32'(bus.fifo_w_en), 0);
    tick();
    bus.grant = 1'b1;
    wait_done(lat);
    check("t4b_done_latency", 32'(lat), 3);
    check_queues("t4b");

    // 5a: zero inner count finishes with no reads
    start_xfer(20'h400, 20'h1, 10'd0, 20'h0, 10'd5);
    wait_done(lat);
    check("t5_zero_done_latency", 32'(lat), 0);

    // 5b: start while busy is ignored
    for (int i = 0; i < 4; i++) expect_rd(20'h500 + AW'(i), 1'b1);
    start_xfer(20'h500, 20'h1, 10'd4, 20'h0, 10'd1);
    tick();
    cfg_addr_begin = 20'h600;
    cfg_inner_cnt  = 10'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("t5_busy_during", 32'(busy), 1);
    wait_done(lat);
    check_queues("t5b");

    // 5c: push into a full FIFO is dropped and flagged, flag is sticky
    bus.fifo_full = 1'b1;
    expect_rd(20'h700, 1'b0);
    start_xfer(20'h700, 20'h1, 10'd1, 20'h0, 10'd1);
    wait_done(lat);
    check("t5_overflow_set", 32'(overflow_err), 1);
    bus.fifo_full = 1'b0;
    expect_rd(20'h710, 1'b1); expect_rd(20'h711, 1'b1);
    start_xfer(20'h710, 20'h1, 10'd2, 20'h0, 10'd1);
    wait_done(lat);
    check("t5_overflow_sticky", 32'(overflow_err), 1);
    check_queues("t5c");

    // 6: reset during a burst aborts cleanly; the second read is never pushed
    expect_rd(20'h800, 1'b1);
    expect_rd(20'h801, 1'b0);
    start_xfer(20'h800, 20'h1, 10'd8, 20'h0, 10'd1);
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_after_rst");
    tick();
    check_queues("t6_abort");
    for (int i = 0; i < 3; i++) expect_rd(20'h900 + AW'(i), 1'b1);
    start_xfer(20'h900, 20'h1, 10'd3, 20'h0, 10'd1);
    wait_done(lat);
    check("t6_rerun_latency", 32'(lat), 5);
    check_queues("t6_rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
